pkt_gen_frame_builder: RTL and testbench

- Downstream stage of the per-flow token scheduler inside the packet generator.
- Accepts one packet task (flow id, L2 size incl. CRC) at a time.
- Emits the frame minus CRC as a 64-bit Avalon-ST stream toward the MAC, which appends the CRC.
- Frame carries fixed MAC/EtherType header, flow id, per-flow 32-bit sequence number and an incrementing byte pattern.

---
 rtl/pkt_gen_pkg.sv | 29 ++
 rtl/pkt_gen_flow_seq_cnt.sv | 51 +++++
 rtl/pkt_gen_frame_builder.sv | 213 +++++++++++++++++++++
 tb/tb_pkt_gen_frame_builder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
// ---------------------------------------------------------------------------
// pkt_gen_pkg
// Shared types and constants for the packet generator frame builder.
//   state_t      : frame builder FSM states (IDLE, HDR0, HDR1, HDR2, PAY)
//   HDR_WORDS    : number of 64-bit header words ahead of the payload
//   MIN_SIZE     : smallest legal L2 frame size, CRC included
//   CRC_LEN      : CRC bytes appended downstream by the MAC
//   flow_width() : width of a flow id for a given flow count
// ---------------------------------------------------------------------------
package pkt_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        PAY
    } state_t;

    localparam int          HDR_WORDS = 3;
    localparam logic [15:0] MIN_SIZE  = 16'd64;
    localparam logic [15:0] CRC_LEN   = 16'd4;

    // A single flow still needs a one-bit id port.
    function automatic int flow_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pkt_gen_flow_seq_cnt.sv
// ---------------------------------------------------------------------------
// pkt_gen_flow_seq_cnt
// Bank of FLOW_CNT independent 32-bit sequence counters, one per flow.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset, clears every counter
//   rd_flow  : flow id for the combinational read port
//   rd_seq   : current counter value of rd_flow
//   inc      : increment strobe (one count per cycle it is high)
//   inc_flow : flow id whose counter is incremented
// ---------------------------------------------------------------------------
module pkt_gen_flow_seq_cnt
    import pkt_gen_pkg::*;
#(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = flow_width(FLOW_CNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLOW_CNT_WIDTH-1:0] rd_flow,
    output logic [31:0]               rd_seq,
    input  logic                      inc,
    input  logic [FLOW_CNT_WIDTH-1:0] inc_flow
);

    logic [FLOW_CNT-1:0][31:0] cnt;

    // Counters wrap naturally from 32'hFFFF_FFFF to 0. Per-entry compare
    // keeps out-of-range ids harmless when FLOW_CNT is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                if (inc && (inc_flow == FLOW_CNT_WIDTH'(i))) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        rd_seq = '0;
        for (int i = 0; i < FLOW_CNT; i++) begin
            if (rd_flow == FLOW_CNT_WIDTH'(i)) begin
                rd_seq = cnt[i];
            end
        end
    end

endmodule

// File: rtl/pkt_gen_frame_builder.sv
// ---------------------------------------------------------------------------
// pkt_gen_frame_builder
// Turns one packet task (flow id, L2 size incl. CRC) into a frame without
// CRC on a 64-bit Avalon-ST stream: fixed MAC/EtherType header, flow id,
// per-flow sequence number, then an incrementing byte pattern.
// Optional feature macro: PKT_GEN_FRAME_TS_EN -- when defined, a free-running
// 32-bit cycle counter is sampled at accept and replaces {16'h0, size} in
// the third header word.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   task_valid_i   : task request valid
//   task_ready_o   : task accept, high only in IDLE
//   task_flow_i    : flow id
//   task_size_i    : L2 size incl. CRC, bytes
//   pkt_data_o     : stream data, first byte in [63:56]
//   pkt_valid_o    : data valid
//   pkt_ready_i    : downstream ready
//   pkt_sop_o      : first word of frame
//   pkt_eop_o      : last word of frame
//   pkt_empty_o    : unused low-end bytes in the eop word
// ---------------------------------------------------------------------------
module pkt_gen_frame_builder
    import pkt_gen_pkg::*;
#(
    parameter int          FLOW_CNT       = 16,
    parameter int          FLOW_CNT_WIDTH = flow_width(FLOW_CNT),
    parameter logic [47:0] DST_MAC        = 48'h00_11_22_33_44_55,
    parameter logic [47:0] SRC_MAC        = 48'h00_AA_BB_CC_DD_EE,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter logic [15:0] MAX_SIZE       = 16'd9600
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      task_valid_i,
    output logic                      task_ready_o,
    input  logic [FLOW_CNT_WIDTH-1:0] task_flow_i,
    input  logic [15:0]               task_size_i,
    output logic [63:0]               pkt_data_o,
    output logic                      pkt_valid_o,
    input  logic                      pkt_ready_i,
    output logic                      pkt_sop_o,
    output logic                      pkt_eop_o,
    output logic [2:0]                pkt_empty_o
);

    state_t                    state;
    logic [FLOW_CNT_WIDTH-1:0] flow_q;
    logic [15:0]               eff_q;
    logic [15:0]               bytes_q;
    logic [31:0]               seq_q;
    logic [10:0]               beat_q;
    logic [10:0]               last_beat_q;
    logic [2:0]                empty_q;

    logic        accept;
    logic [31:0] cur_seq;
    logic        seq_inc;
    logic [15:0] clamp_size;
    logic [15:0] acc_bytes;
    logic [10:0] acc_last;
    logic [10:0] next_beat;
    logic [15:0] next_base;
    logic [15:0] byte_idx;
    logic [63:0] next_pay;
    logic [63:0] hdr0;
    logic [63:0] hdr1;
    logic [63:0] hdr2;

    assign accept  = task_valid_i && task_ready_o;
    assign seq_inc = (state == PAY) && pkt_valid_o && pkt_ready_i && pkt_eop_o;

    pkt_gen_flow_seq_cnt #(
        .FLOW_CNT       (FLOW_CNT),
        .FLOW_CNT_WIDTH (FLOW_CNT_WIDTH)
    ) u_seq_cnt (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .rd_flow  (task_flow_i),
        .rd_seq   (cur_seq),
        .inc      (seq_inc),
        .inc_flow (flow_q)
    );

    // Clamp the requested size, then derive the CRC-less byte count and the
    // index of the last beat. Sizes are at least 64, so a frame always has
    // more beats than header words and the eop never lands on a header word.
    always_comb begin
        clamp_size = (task_size_i > MAX_SIZE) ? MAX_SIZE : task_size_i;
        if (clamp_size < MIN_SIZE) begin
            clamp_size = MIN_SIZE;
        end
        acc_bytes = clamp_size - CRC_LEN;
        acc_last  = 11'((acc_bytes + 16'd7) >> 3) - 11'd1;
    end

    // Payload word for the beat after the current one: byte k carries k[7:0],
    // bytes past the end of the frame are zero.
    always_comb begin
        next_beat = beat_q + 11'd1;
        next_base = {2'b00, next_beat, 3'b000};
        next_pay  = '0;
        byte_idx  = '0;
        for (int j = 0; j < 8; j++) begin
            byte_idx = next_base + 16'(j);
            if (byte_idx < bytes_q) begin
                next_pay[63-8*j -: 8] = byte_idx[7:0];
            end
        end
    end

    assign hdr0 = {DST_MAC, SRC_MAC[47:32]};
    assign hdr1 = {SRC_MAC[31:0], ETHERTYPE, 16'(flow_q)};

`ifdef PKT_GEN_FRAME_TS_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_q;

    // Free-running cycle counter, captured when a task is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (accept) begin
                ts_q <= ts_cnt;
            end
        end
    end

    assign hdr2 = {seq_q, ts_q};
`else
    assign hdr2 = {seq_q, 16'h0000, eff_q};
`endif

    // Frame FSM with registered stream outputs. Each output word is loaded
    // when the previous one is taken, so a stalled word simply stays put.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            task_ready_o <= 1'b0;
            pkt_data_o   <= '0;
            pkt_valid_o  <= 1'b0;
            pkt_sop_o    <= 1'b0;
            pkt_eop_o    <= 1'b0;
            pkt_empty_o  <= '0;
            flow_q       <= '0;
            eff_q        <= '0;
            bytes_q      <= '0;
            seq_q        <= '0;
            beat_q       <= '0;
            last_beat_q  <= '0;
            empty_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    task_ready_o <= 1'b1;
                    if (accept) begin
                        flow_q       <= task_flow_i;
                        eff_q        <= clamp_size;
                        bytes_q      <= acc_bytes;
                        seq_q        <= cur_seq;
                        last_beat_q  <= acc_last;
                        empty_q      <= 3'd0 - acc_bytes[2:0];
                        beat_q       <= '0;
                        task_ready_o <= 1'b0;
                        pkt_valid_o  <= 1'b1;
                        pkt_sop_o    <= 1'b1;
                        pkt_data_o   <= hdr0;
                        state        <= HDR0;
                    end
                end
                HDR0: begin
                    if (pkt_ready_i) begin
                        pkt_sop_o  <= 1'b0;
                        pkt_data_o <= hdr1;
                        beat_q     <= next_beat;
                        state      <= HDR1;
                    end
                end
                HDR1: begin
                    if (pkt_ready_i) begin
                        pkt_data_o <= hdr2;
                        beat_q     <= next_beat;
                        state      <= HDR2;
                    end
                end
                HDR2, PAY: begin
                    if (pkt_ready_i) begin
                        if (pkt_eop_o) begin
                            pkt_valid_o  <= 1'b0;
                            pkt_eop_o    <= 1'b0;
                            pkt_empty_o  <= '0;
                            pkt_data_o   <= '0;
                            task_ready_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            pkt_data_o  <= next_pay;
                            beat_q      <= next_beat;
                            pkt_eop_o   <= (next_beat == last_beat_q);
                            pkt_empty_o <= (next_beat == last_beat_q) ? empty_q : 3'd0;
                            state       <= PAY;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_gen_frame_builder.sv
// ---------------------------------------------------------------------------
// tb_pkt_gen_frame_builder
// Self-checking bench for pkt_gen_frame_builder. Tasks are issued with
// applyStimulus, which builds the whole expected frame byte by byte from
// the frame layout and queues its beats; an independent monitor pops and
// compares every accepted beat and checks that stalled words stay stable.
// Honours PKT_GEN_FRAME_TS_EN for the timestamp header field.
// ---------------------------------------------------------------------------
module tb_pkt_gen_frame_builder;

    localparam int          FLOW_CNT  = 16;
    localparam logic [47:0] DST_MAC   = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SRC_MAC   = 48'h00_AA_BB_CC_DD_EE;
    localparam logic [15:0] ETHERTYPE = 16'h88B5;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic        clk_i;
    logic        rst_n_i;
    logic        task_valid_i;
    logic        task_ready_o;
    logic [3:0]  task_flow_i;
    logic [15:0] task_size_i;
    logic [63:0] pkt_data_o;
    logic        pkt_valid_o;
    logic        pkt_ready_i;
    logic        pkt_sop_o;
    logic        pkt_eop_o;
    logic [2:0]  pkt_empty_o;

    int          compareCount = 0;
    int          failCount    = 0;
    int          beatsSeen    = 0;
    int          readyMode    = 0;
    logic [31:0] modelSeq [FLOW_CNT];
    beat_t       expQ [$];

`ifdef PKT_GEN_FRAME_TS_EN
    logic [31:0] tbCycle;
    logic [31:0] tsExp;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tbCycle <= '0;
        else          tbCycle <= tbCycle + 32'd1;
    end
`endif

    pkt_gen_frame_builder dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .task_valid_i (task_valid_i),
        .task_ready_o (task_ready_o),
        .task_flow_i  (task_flow_i),
        .task_size_i  (task_size_i),
        .pkt_data_o   (pkt_data_o),
        .pkt_valid_o  (pkt_valid_o),
        .pkt_ready_i  (pkt_ready_i),
        .pkt_sop_o    (pkt_sop_o),
        .pkt_eop_o    (pkt_eop_o),
        .pkt_empty_o  (pkt_empty_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Downstream ready: always on, alternating, or ~30% random stalls.
    initial begin
        pkt_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                1:       pkt_ready_i = ~pkt_ready_i;
                2:       pkt_ready_i = ($urandom_range(0, 99) >= 30);
                default: pkt_ready_i = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Byte k of the frame as laid out on the wire.
    function automatic logic [7:0] frameByte(input int k, input int flow,
                                             input int eff, input logic [31:0] seq);
        logic [191:0] hdr;
`ifdef PKT_GEN_FRAME_TS_EN
        hdr = {DST_MAC, SRC_MAC, ETHERTYPE, 16'(flow), seq, tsExp};
        if (eff < 0) hdr = '0;
`else
        hdr = {DST_MAC, SRC_MAC, ETHERTYPE, 16'(flow), seq, 16'h0000, 16'(eff)};
`endif
        if (k < 24) return hdr[191-8*k -: 8];
        return 8'(k % 256);
    endfunction

    task automatic pushFrame(input int flow, input int size);
        int    eff;
        int    nBytes;
        int    nWords;
        int    k;
        beat_t b;
        eff = size;
        if (eff > 9600) eff = 9600;
        if (eff < 64)   eff = 64;
        nBytes = eff - 4;
        nWords = (nBytes + 7) / 8;
        for (int w = 0; w < nWords; w++) begin
            b.data = '0;
            for (int j = 0; j < 8; j++) begin
                k = 8 * w + j;
                if (k < nBytes) b.data[63-8*j -: 8] = frameByte(k, flow, eff, modelSeq[flow]);
            end
            b.sop   = (w == 0);
            b.eop   = (w == nWords - 1);
            b.empty = b.eop ? 3'(nWords * 8 - nBytes) : 3'd0;
            expQ.push_back(b);
        end
        modelSeq[flow] = modelSeq[flow] + 32'd1;
    endtask

    task automatic applyStimulus(input int flow, input int size);
        int n = 0;
        @(negedge clk_i);
        while (!task_ready_o && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("taskReadyWait", task_ready_o, 1);
        if (!task_ready_o) return;
`ifdef PKT_GEN_FRAME_TS_EN
        tsExp = tbCycle;
`endif
        pushFrame(flow, size);
        task_valid_i = 1'b1;
        task_flow_i  = 4'(flow);
        task_size_i  = 16'(size);
        @(negedge clk_i);
        task_valid_i = 1'b0;
        task_flow_i  = 4'($urandom_range(0, 15));
        task_size_i  = 16'($urandom);
        checkOutput("firstBeatLatency", {pkt_valid_o, pkt_sop_o}, 2'b11);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (!(expQ.size() == 0 && task_ready_o) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drainTimeout", expQ.size(), 0);
    endtask

    // Monitor: compares every accepted beat and verifies stalled words hold.
    initial begin : monitor
        beat_t b;
        logic        stallHeld = 1'b0;
        logic [63:0] heldData  = '0;
        logic [4:0]  heldCtrl  = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                stallHeld = 1'b0;
            end else begin
                if (stallHeld) begin
                    checkOutput("stallValid", pkt_valid_o, 1);
                    checkOutput("stallData", pkt_data_o, heldData);
                    checkOutput("stallCtrl", {pkt_sop_o, pkt_eop_o, pkt_empty_o}, heldCtrl);
                end
                if (pkt_valid_o && pkt_ready_i) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedBeat", pkt_data_o, 64'h0);
                    end else begin
                        b = expQ.pop_front();
                        checkOutput("beatData", pkt_data_o, b.data);
                        checkOutput("beatCtrl", {pkt_sop_o, pkt_eop_o, pkt_empty_o},
                                    {b.sop, b.eop, b.empty});
                    end
                    beatsSeen++;
                end
                stallHeld = pkt_valid_o && !pkt_ready_i;
                heldData  = pkt_data_o;
                heldCtrl  = {pkt_sop_o, pkt_eop_o, pkt_empty_o};
            end
        end
    end

    initial begin : stimulus
        int start;
        int cyc;
        int n;
        logic [15:0][31:0] preload;

        rst_n_i      = 1'b1;
        task_valid_i = 1'b0;
        task_flow_i  = '0;
        task_size_i  = '0;
        foreach (modelSeq[i]) modelSeq[i] = '0;
        #1 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("resetTaskReady", task_ready_o, 0);
        checkOutput("resetValid", pkt_valid_o, 0);
        checkOutput("resetData", pkt_data_o, 64'h0);
        checkOutput("resetCtrl", {pkt_sop_o, pkt_eop_o, pkt_empty_o}, 5'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        checkOutput("readyAfterReset", task_ready_o, 1);

        // Minimum frame, ready always high, ready returns at cycle 9.
        readyMode = 0;
        start = beatsSeen;
        applyStimulus(0, 64);
        cyc = 1;
        while (!task_ready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput("readyReturnCycle", cyc, 9);
        waitDrain();
        checkOutput("beats64", beatsSeen - start, 8);

        // Same flow twice: sequence 0 then 1; flow 0 keeps its own count.
        for (int r = 0; r < 2; r++) begin
            start = beatsSeen;
            applyStimulus(5, 1500);
            waitDrain();
            checkOutput("beats1500", beatsSeen - start, 187);
        end
        applyStimulus(0, 64);
        waitDrain();

        // Backpressure: alternating then random stalls.
        readyMode = 1;
        applyStimulus(2, 1500);
        waitDrain();
        readyMode = 2;
        applyStimulus(7, 1500);
        waitDrain();
        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 2500));
        end
        waitDrain();

        // Size clamps at both ends.
        start = beatsSeen;
        applyStimulus(1, 20);
        waitDrain();
        checkOutput("beatsClampLow", beatsSeen - start, 8);
        start = beatsSeen;
        applyStimulus(4, 16'hFFFF);
        waitDrain();
        checkOutput("beatsClampHigh", beatsSeen - start, 1200);

        // Sequence wrap on flow 3 from a preloaded all-ones count.
        readyMode = 0;
        @(negedge clk_i);
        for (int i = 0; i < FLOW_CNT; i++) preload[i] = modelSeq[i];
        preload[3]  = 32'hFFFF_FFFF;
        modelSeq[3] = 32'hFFFF_FFFF;
        force dut.u_seq_cnt.cnt = preload;
        @(negedge clk_i);
        release dut.u_seq_cnt.cnt;
        applyStimulus(3, 64);
        waitDrain();
        applyStimulus(3, 64);
        waitDrain();

        // Reset in the middle of a frame, then a clean frame afterwards.
        start = beatsSeen;
        applyStimulus(6, 1024);
        n = 0;
        while ((beatsSeen - start) < 50 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("reachBeat50", (beatsSeen - start) >= 50, 1);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("midResetValid", pkt_valid_o, 0);
        checkOutput("midResetData", pkt_data_o, 64'h0);
        checkOutput("midResetCtrl", {pkt_sop_o, pkt_eop_o, pkt_empty_o}, 5'h0);
        checkOutput("midResetReady", task_ready_o, 0);
        expQ.delete();
        foreach (modelSeq[i]) modelSeq[i] = '0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        start = beatsSeen;
        applyStimulus(9, 128);
        waitDrain();
        checkOutput("beatsAfterReset", beatsSeen - start, 16);

        repeat (5) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
        $finish;
    end

endmodule
